// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the pipeline writeback (fixed priority)
// and a small ordered buffer of multi-cycle results, with a per-register pending scoreboard.
module regfile_wr_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_dr,
    input  logic [31:0]   pipe_data,
    input  logic          mc_valid,
    output logic          mc_ready,
    input  logic [4:0]    mc_dr,
    input  logic [31:0]   mc_data,
    output logic          WReg,
    output logic [4:0]    DR,
    output logic [31:0]   Data_in,
    input  logic [4:0]    q1_reg,
    input  logic [4:0]    q2_reg,
    output logic          q1_busy,
    output logic          q2_busy,
    output logic [AW:0]   pend_cnt
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [4:0]       dr_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      cnt_reg;
    logic [AW:0]      cnt_next;

    logic pipe_act;
    logic empty;
    logic pop;
    logic handshake;
    logic push;

    logic [DEPTH-1:0] squash;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    assign pipe_act  = pipe_we && (pipe_dr != 5'd0);
    assign empty     = (cnt_reg == '0);
    assign pop       = !pipe_act && !empty;
    assign mc_ready  = (cnt_reg != (AW+1)'(DEPTH));
    assign handshake = mc_valid && mc_ready;
    // Results to r0, or overwritten by a same-cycle younger pipeline write, are dropped.
    assign push      = handshake && (mc_dr != 5'd0) && !(pipe_act && (mc_dr == pipe_dr));
    assign pend_cnt  = cnt_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign squash[gi] = pipe_act && valid_reg[gi] && (dr_mem[gi] == pipe_dr);
            assign hit1[gi]   = valid_reg[gi] && (dr_mem[gi] == q1_reg);
            assign hit2[gi]   = valid_reg[gi] && (dr_mem[gi] == q2_reg);
        end
    endgenerate

    assign q1_busy = (q1_reg != 5'd0) && (|hit1);
    assign q2_busy = (q2_reg != 5'd0) && (|hit2);

    always_comb begin
        WReg    = 1'b0;
        DR      = 5'd0;
        Data_in = 32'd0;
        if (pipe_act) begin
            WReg    = 1'b1;
            DR      = pipe_dr;
            Data_in = pipe_data;
        end else if (!empty) begin
            // A squashed head still pops, just without a write.
            WReg    = valid_reg[rd_ptr_reg];
            DR      = dr_mem[rd_ptr_reg];
            Data_in = data_mem[rd_ptr_reg];
        end
    end

    always_comb begin
        valid_next = valid_reg & ~squash;
        if (pop) begin
            valid_next[rd_ptr_reg] = 1'b0;
        end
        if (push) begin
            valid_next[wr_ptr_reg] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Payload needs no reset: the valid bits and occupancy gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            dr_mem[wr_ptr_reg]   <= mc_dr;
            data_mem[wr_ptr_reg] <= mc_data;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: a queue of expected buffered writes is pushed on accepted
// handshakes and popped/compared against the write port on free cycles.
module tb_regfile_wr_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          pipe_we;
    logic [4:0]    pipe_dr;
    logic [31:0]   pipe_data;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_dr;
    logic [31:0]   mc_data;
    logic          WReg;
    logic [4:0]    DR;
    logic [31:0]   Data_in;
    logic [4:0]    q1_reg;
    logic [4:0]    q2_reg;
    logic          q1_busy;
    logic          q2_busy;
    logic [AW:0]   pend_cnt;

    regfile_wr_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_dr   (pipe_dr),
        .pipe_data (pipe_data),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_dr     (mc_dr),
        .mc_data   (mc_data),
        .WReg      (WReg),
        .DR        (DR),
        .Data_in   (Data_in),
        .q1_reg    (q1_reg),
        .q2_reg    (q2_reg),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy),
        .pend_cnt  (pend_cnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  dr;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && WReg) begin
            rf[DR] <= Data_in;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational outputs
    // against the model, then advance the model to the next rising edge.
    task automatic step(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        logic        pact;
        logic        full;
        logic        b1;
        logic        b2;
        logic [37:0] ew;
        ent_t        e;
        @(negedge clk);
        pipe_we   = pw;
        pipe_dr   = pd;
        pipe_data = pdat;
        mc_valid  = mv;
        mc_dr     = md;
        mc_data   = mdat;
        #1;
        pact = pw && (pd != 5'd0);
        full = (exp_q.size() == DEPTH);
        b1 = 1'b0;
        b2 = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i].v && exp_q[i].dr == q1_reg && q1_reg != 5'd0) b1 = 1'b1;
            if (exp_q[i].v && exp_q[i].dr == q2_reg && q2_reg != 5'd0) b2 = 1'b1;
        end
        if (pact)                   ew = {1'b1, pd, pdat};
        else if (exp_q.size() > 0)  ew = {exp_q[0].v, exp_q[0].dr, exp_q[0].data};
        else                        ew = '0;
        check_val("mc_ready", 64'(mc_ready), 64'(!full));
        check_val("pend_cnt", 64'(pend_cnt), 64'(exp_q.size()));
        check_val("q1_busy",  64'(q1_busy),  64'(b1));
        check_val("q2_busy",  64'(q2_busy),  64'(b2));
        check_val("write",    64'({WReg, DR, Data_in}), 64'(ew));
        $display("t=%0t pw=%0b pd=%0d mv=%0b md=%0d rdy=%0b WReg=%0b DR=%0d Data_in=0x%0h cnt=%0d",
                 $time, pw, pd, mv, md, mc_ready, WReg, DR, Data_in, pend_cnt);
        if (pact) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].dr == pd) exp_q[i].v = 1'b0;
            end
            exp_rf[pd] = pdat;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.v) exp_rf[e.dr] = e.data;
        end
        if (mv && !full && md != 5'd0 && !(pact && md == pd)) begin
            e.v    = 1'b1;
            e.dr   = md;
            e.data = mdat;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_rf(input int r, input string tag);
        @(negedge clk);
        check_val(tag, 64'(rf[r]), 64'(exp_rf[r]));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]     = 32'd0;
            exp_rf[i] = 32'd0;
        end
        rst_n = 1'b0;
        pipe_we = 1'b0; pipe_dr = '0; pipe_data = '0;
        mc_valid = 1'b0; mc_dr = '0; mc_data = '0;
        q1_reg = '0; q2_reg = '0;
        #12 rst_n = 1'b1;

        // Reset state and idle drain
        idle();
        q1_reg = 5'd5;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        idle();
        idle();
        check_rf(5, "rf_r5");

        // Priority and backpressure, then full with a simultaneous pop
        q1_reg = 5'd7; q2_reg = 5'd9;
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd3, 32'h300 + 32'(i), 1'b1, 5'(6 + i), 32'h600 + 32'(i));
        step(1'b1, 5'd3, 32'h3FF, 1'b1, 5'd11, 32'hB11);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC12);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC12);
        for (int i = 0; i < 5; i++) idle();
        check_rf(12, "rf_r12");

        // Squash of a buffered write by a younger pipeline write
        q1_reg = 5'd10;
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hAA);
        step(1'b1, 5'd10, 32'hBB, 1'b0, 5'd0, 32'd0);
        idle();
        idle();
        check_rf(10, "rf_r10");

        // Same-cycle conflict and r0 results
        step(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 32'h44);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        idle();
        check_rf(4, "rf_r4");
        check_val("rf_r0", 64'(rf[0]), 64'd0);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            q1_reg = 5'($urandom_range(0, 7));
            q2_reg = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 6; i++) idle();
        for (int r = 0; r < 8; r++) check_rf(r, "rf_rand");

        // Asynchronous reset with pending entries
        q1_reg = 5'd20;
        step(1'b1, 5'd3, 32'h1, 1'b1, 5'd20, 32'h20);
        step(1'b1, 5'd3, 32'h2, 1'b1, 5'd21, 32'h21);
        step(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22);
        @(negedge clk);
        pipe_we = 1'b0; mc_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_pend_cnt", 64'(pend_cnt), 64'd0);
        check_val("rst_mc_ready", 64'(mc_ready), 64'd1);
        check_val("rst_q1_busy",  64'(q1_busy),  64'd0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();
        check_rf(20, "rf_r20");
        check_rf(22, "rf_r22");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
